// File: rtl/avsd_sar_adc_ctrl_if.sv
// Handshake/analog-side bundle for the SAR controller.
// The slave modport is the controller; the master modport is the digital core
// together with the analog front end (START/ABORT requests, comparator result).
interface avsd_sar_adc_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             START;
  logic             ABORT;
  logic             CMP;
  logic [WIDTH-1:0] DAC_D;
  logic             SAMPLE;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DOUT;

  modport master (
    output START, ABORT, CMP,
    input  DAC_D, SAMPLE, BUSY, DONE, DOUT
  );

  modport slave (
    input  START, ABORT, CMP,
    output DAC_D, SAMPLE, BUSY, DONE, DOUT
  );
endinterface

// File: rtl/avsd_sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples, then resolves one result
// bit per settle window (MSB first) by driving trial codes to the DAC and
// reading the comparator; reports the result with a BUSY/DONE handshake.
module avsd_sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input logic               CLK,
  input logic               reset,
  avsd_sar_adc_ctrl_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAMP  = 2'd1,
    ST_TRIAL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [TW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] res_keep;

  // One-hot mask of the bit under trial and the result with the comparator
  // decision for that bit folded in.
  always_comb begin
    trial_bit = WIDTH'(1) << bit_q;
    res_keep  = bus.CMP ? (res_q | trial_bit) : res_q;
  end

  // State and datapath registers; reset clears everything including DOUT.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      samp_cnt_q   <= '0;
      settle_cnt_q <= '0;
      bit_q        <= '0;
      res_q        <= '0;
      dout_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      bit_q        <= bit_d;
      res_q        <= res_d;
      dout_q       <= dout_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic: sample countdown, per-bit settle countdown, bit capture.
  // ABORT is tested before the window-end capture so it wins over completion.
  always_comb begin
    state_d      = state_q;
    samp_cnt_d   = samp_cnt_q;
    settle_cnt_d = settle_cnt_q;
    bit_d        = bit_q;
    res_d        = res_q;
    dout_d       = dout_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d    = ST_SAMP;
          res_d      = '0;
          samp_cnt_d = SW'(SAMPLE_CYCLES - 1);
        end
      end

      ST_SAMP: begin
        if (bus.ABORT) begin
          state_d = ST_IDLE;
        end else if (samp_cnt_q == '0) begin
          state_d      = ST_TRIAL;
          bit_d        = IW'(WIDTH - 1);
          settle_cnt_d = TW'(SETTLE_CYCLES - 1);
        end else begin
          samp_cnt_d = samp_cnt_q - SW'(1);
        end
      end

      ST_TRIAL: begin
        if (bus.ABORT) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == '0) begin
          res_d = res_keep;
          if (bit_q == '0) begin
            state_d = ST_IDLE;
            dout_d  = res_keep;
            done_d  = 1'b1;
          end else begin
            bit_d        = bit_q - IW'(1);
            settle_cnt_d = TW'(SETTLE_CYCLES - 1);
          end
        end else begin
          settle_cnt_d = settle_cnt_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so reset forces them low.
  always_comb begin
    bus.BUSY   = (state_q != ST_IDLE);
    bus.SAMPLE = (state_q == ST_SAMP);
    bus.DAC_D  = (state_q == ST_TRIAL) ? (res_q | trial_bit) : '0;
    bus.DONE   = done_q;
    bus.DOUT   = dout_q;
  end

endmodule
